duty_ramp_ctrl: RTL and testbench

DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

---
 rtl/duty_ramp_pkg.sv | 15 +
 rtl/pwm_period_cnt.sv | 30 +++
 rtl/duty_ramp_ctrl.sv | 136 +++++++++++++
 tb/tb_duty_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_pkg.sv
// Shared types and default widths for the duty ramp controller.
package duty_ramp_pkg;

  localparam int DEF_DUTY_WIDTH = 8;
  localparam int DEF_STEP_WIDTH = 4;
  localparam int DEF_DIV_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter; period_tick marks the last cycle of each period.
module pwm_period_cnt
  import duty_ramp_pkg::*;
#(
  parameter int DUTY_WIDTH = DEF_DUTY_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam logic [DUTY_WIDTH-1:0] CNT_PRE = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};

  logic [DUTY_WIDTH-1:0] cnt_q;
  logic                  tick_q;

  // Tick is registered one cycle early so it is high exactly while cnt_q == max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= (cnt_q == CNT_PRE);
    end
  end

  assign period_tick = tick_q;

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Ramps a PWM duty value toward a commanded target in period-aligned steps,
// with an emergency stop that forces the duty to zero.
module duty_ramp_ctrl
  import duty_ramp_pkg::*;
#(
  parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DUTY_WIDTH-1:0] cmd_duty,
  input  logic [STEP_WIDTH-1:0] cmd_step,
  input  logic [DIV_WIDTH-1:0]  cmd_div,
  input  logic                  estop,
  output logic [DUTY_WIDTH-1:0] duty_out,
  output logic                  period_tick,
  output logic                  busy,
  output logic                  done
);

  localparam int EW = DUTY_WIDTH + STEP_WIDTH;

  state_e                state_q, state_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic [DUTY_WIDTH-1:0] tgt_q, tgt_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  dcnt_q, dcnt_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;

  logic                  tick;
  logic                  accept;
  logic                  up;
  logic [EW-1:0]         duty_x, tgt_x, step_x, diff_x;
  logic [DUTY_WIDTH-1:0] step_duty;

  pwm_period_cnt #(.DUTY_WIDTH(DUTY_WIDTH)) u_period (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (tick)
  );

  assign cmd_ready = (state_q != STOP) && !estop;
  assign accept    = cmd_valid && cmd_ready;

  // Distance is compared at extended width so a wide step never aliases.
  always_comb begin
    duty_x = {{STEP_WIDTH{1'b0}}, duty_q};
    tgt_x  = {{STEP_WIDTH{1'b0}}, tgt_q};
    step_x = {{DUTY_WIDTH{1'b0}}, step_q};
    up     = tgt_x > duty_x;
    diff_x = up ? (tgt_x - duty_x) : (duty_x - tgt_x);
    if (step_q == '0 || diff_x <= step_x) step_duty = tgt_q;
    else if (up)                          step_duty = duty_q + DUTY_WIDTH'(step_q);
    else                                  step_duty = duty_q - DUTY_WIDTH'(step_q);
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    div_d   = div_q;
    dcnt_d  = dcnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    if (estop) begin
      state_d = STOP;
      duty_d  = '0;
      tgt_d   = '0;
      dcnt_d  = '0;
      pend_d  = 1'b0;
    end else if (state_q == STOP) begin
      state_d = IDLE;
    end else if (accept) begin
      // A command wins over a same-edge step; the step is simply dropped.
      tgt_d  = cmd_duty;
      step_d = cmd_step;
      div_d  = cmd_div;
      dcnt_d = '0;
      if (cmd_duty == duty_q) begin
        state_d = HOLD;
        pend_d  = 1'b1;
      end else begin
        state_d = RAMP;
        pend_d  = 1'b0;
      end
    end else if (tick && pend_q) begin
      done_d = 1'b1;
      pend_d = 1'b0;
    end else if (tick && state_q == RAMP) begin
      if (dcnt_q == div_q) begin
        dcnt_d = '0;
        duty_d = step_duty;
        if (step_duty == tgt_q) begin
          done_d  = 1'b1;
          state_d = HOLD;
        end
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      div_q   <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      div_q   <= div_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign duty_out    = duty_q;
  assign period_tick = tick;
  assign busy        = (state_q == RAMP);
  assign done        = done_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: directed ramp scenarios plus random commands/estops,
// all checked every cycle against an arithmetic reference model.
module tb_duty_ramp_ctrl;

  localparam int DW   = 8;
  localparam int SW   = 4;
  localparam int VW   = 8;
  localparam int PMAX = (1 << DW) - 1;

  localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_STOP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          estop = 1'b0;
  logic [DW-1:0] cmd_duty = '0;
  logic [SW-1:0] cmd_step = '0;
  logic [VW-1:0] cmd_div = '0;
  logic          cmd_ready, period_tick, busy, done;
  logic [DW-1:0] duty_out;

  int n_chk = 0, n_err = 0, n_done = 0;

  int m_mode = M_IDLE, m_duty = 0, m_tgt = 0, m_step = 0, m_div = 0;
  int m_dcnt = 0, m_cnt = 0, m_pend = 0, m_tick = 0, m_done = 0;

  duty_ramp_ctrl #(.DUTY_WIDTH(DW), .STEP_WIDTH(SW), .DIV_WIDTH(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_step    (cmd_step),
    .cmd_div     (cmd_div),
    .estop       (estop),
    .duty_out    (duty_out),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_duty = 0; m_tgt = 0; m_step = 0; m_div = 0;
    m_dcnt = 0; m_cnt = 0; m_pend = 0; m_tick = 0; m_done = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    int tk, gap;
    tk = m_tick;
    m_done = 0;
    if (estop) begin
      m_mode = M_STOP; m_duty = 0; m_tgt = 0; m_dcnt = 0; m_pend = 0;
    end else if (m_mode == M_STOP) begin
      m_mode = M_IDLE;
    end else if (cmd_valid) begin
      m_tgt = int'(cmd_duty); m_step = int'(cmd_step); m_div = int'(cmd_div); m_dcnt = 0;
      if (m_tgt == m_duty) begin m_mode = M_HOLD; m_pend = 1; end
      else begin m_mode = M_RAMP; m_pend = 0; end
    end else if (tk != 0 && m_pend != 0) begin
      m_done = 1; m_pend = 0;
    end else if (tk != 0 && m_mode == M_RAMP) begin
      if (m_dcnt == m_div) begin
        m_dcnt = 0;
        gap = m_tgt - m_duty;
        if (m_step == 0 || (gap < 0 ? -gap : gap) <= m_step) m_duty = m_tgt;
        else m_duty = m_duty + (gap > 0 ? m_step : -m_step);
        if (m_duty == m_tgt) begin m_done = 1; m_mode = M_HOLD; end
      end else begin
        m_dcnt++;
      end
    end
    m_cnt  = (m_cnt + 1) % (PMAX + 1);
    m_tick = (m_cnt == PMAX) ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("duty", int'(duty_out), m_duty);
    chk("tick", int'(period_tick), m_tick);
    chk("busy", int'(busy), (m_mode == M_RAMP) ? 1 : 0);
    chk("done", int'(done), m_done);
    chk("ready", int'(cmd_ready), (m_mode != M_STOP && !estop) ? 1 : 0);
    if (done) n_done++;
  endtask

  task automatic send(input int d, input int s, input int v);
    cmd_duty = DW'(d); cmd_step = SW'(s); cmd_div = VW'(v);
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_duty(input string tag, input int val, input int bound);
    int c = 0;
    while (int'(duty_out) != val && c < bound) begin cyc(); c++; end
    if (int'(duty_out) != val) chk({tag, "_timeout"}, int'(duty_out), val);
  endtask

  task automatic wait_done(input string tag, input int bound, output int lat);
    lat = 0;
    do begin cyc(); lat++; end while (!done && lat < bound);
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Follows a ramp until done, checking each new duty value and the spacing of steps.
  task automatic ramp_watch(input string tag, input int first, input int delta, input int last,
                            input int gap, input int bound, output int nsteps);
    int prev, k, last_c, dn, e;
    prev = int'(duty_out); k = 0; last_c = 0; dn = 0;
    for (int c = 0; c < bound && dn == 0; c++) begin
      cyc();
      if (int'(duty_out) != prev) begin
        e = first + k * delta;
        if ((delta < 0 && e < last) || (delta > 0 && e > last)) e = last;
        chk({tag, "_val"}, int'(duty_out), e);
        if (k > 0) chk({tag, "_gap"}, c - last_c, gap);
        last_c = c; k++; prev = int'(duty_out);
      end
      if (done) dn++;
    end
    if (dn == 0) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_final"}, int'(duty_out), last);
    nsteps = k;
  endtask

  initial begin
    int ns, d0, lat, n;
    #1;
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Up-ramp 0 -> 100, step 10, a step every tick.
    d0 = n_done;
    send(100, 10, 0);
    ramp_watch("up", 10, 10, 100, 256, 4000, ns);
    chk("up_steps", ns, 10);
    repeat (600) cyc();
    chk("up_done_once", n_done - d0, 1);
    chk("up_hold", int'(duty_out), 100);

    // Down-ramp 100 -> 3, step 7, every second tick, last step clamped.
    d0 = n_done;
    send(3, 7, 1);
    ramp_watch("down", 93, -7, 3, 512, 9000, ns);
    chk("down_steps", ns, 14);
    chk("down_done_once", n_done - d0, 1);

    // Mid-ramp retarget: heading to 200, redirect to 20 at duty 50.
    send(0, 0, 0);
    wait_done("jump0", 600, lat);
    d0 = n_done;
    send(200, 10, 0);
    wait_duty("to50", 50, 2000);
    send(20, 5, 0);
    ramp_watch("retgt", 45, -5, 20, 256, 3000, ns);
    chk("retgt_steps", ns, 6);
    repeat (300) cyc();
    chk("retgt_done_once", n_done - d0, 1);

    // Estop with a command presented at the same time.
    send(200, 10, 0);
    wait_duty("to60", 60, 2000);
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd123; cmd_step = 4'd1; cmd_div = '0;
    cyc();
    chk("estop_duty", int'(duty_out), 0);
    chk("estop_ready", int'(cmd_ready), 0);
    chk("estop_busy", int'(busy), 0);
    repeat (3) cyc();
    estop = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    chk("estop_idle_busy", int'(busy), 0);
    chk("estop_idle_ready", int'(cmd_ready), 1);
    chk("estop_idle_duty", int'(duty_out), 0);

    // Jump to full scale, then the same target again.
    send(255, 0, 0);
    wait_done("jump", 600, lat);
    chk("jump_duty", int'(duty_out), 255);
    chk("jump_one_tick", (lat <= 256) ? 1 : 0, 1);
    send(255, 0, 0);
    wait_done("equal", 600, lat);
    chk("equal_duty", int'(duty_out), 255);
    chk("equal_one_tick", (lat <= 256) ? 1 : 0, 1);

    // Asynchronous reset in the middle of a period while ramping.
    send(0, 1, 0);
    repeat (700) cyc();
    chk("pre_rst_busy", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_duty", int'(duty_out), 0);
    chk("arst_tick", int'(period_tick), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    d0 = n_done;
    n = 0;
    do begin cyc(); n++; end while (!period_tick && n < 400);
    chk("rst_first_tick", n, 255);
    chk("rst_no_done", n_done - d0, 0);

    // Random commands and estops, some landing exactly on a tick edge.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        estop = 1'b1;
        repeat ($urandom_range(1, 5)) begin
          cmd_valid = $urandom_range(0, 1) == 1;
          cmd_duty = DW'($urandom_range(0, PMAX));
          cyc();
        end
        estop = 1'b0; cmd_valid = 1'b0;
      end else begin
        if (i % 4 == 0) begin
          n = 0;
          while (m_tick == 0 && n < 300) begin cyc(); n++; end
        end
        send($urandom_range(0, PMAX), $urandom_range(0, 15), $urandom_range(0, 2));
      end
      repeat ($urandom_range(1, 700)) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
